// File: rtl/reg_file_sweeper.sv
// Initiator engine for the register file: either streams every register out as
// (address, data) beats over valid/ready, or fills every register with FILL.
module reg_file_sweeper #(
    parameter int unsigned      ADDR_W = 5,
    parameter int unsigned      DATA_W = 32,
    parameter int unsigned      N_REGS = 32,
    parameter logic [DATA_W-1:0] FILL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_CLEAR,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;

    assign idx_next = idx + ADDR_W'(1);

    // Sweep sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_raddr  <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            rf_we     <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                        if (mode) begin
                            state    <= S_CLEAR;
                            rf_we    <= 1'b1;
                            rf_waddr <= '0;
                            rf_wdata <= FILL;
                        end else begin
                            state    <= S_ISSUE;
                            rf_raddr <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                // Address has been stable for two cycles, so read data is valid here.
                S_WAIT: begin
                    out_addr  <= idx;
                    out_data  <= rf_rdata;
                    out_valid <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            idx      <= idx_next;
                            rf_raddr <= idx_next;
                            state    <= S_ISSUE;
                        end
                    end
                end
                // One write per cycle; the last write happens before leaving.
                S_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        rf_we    <= 1'b0;
                        rf_wdata <= '0;
                        done     <= 1'b1;
                        state    <= S_FIN;
                    end else begin
                        idx      <= idx_next;
                        rf_waddr <= idx_next;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_sweeper.sv
// Bench for reg_file_sweeper: drives a register-file model and checks dump and
// clear sweeps against an array-based expectation of register contents.
module tb_reg_file_sweeper;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam logic [DW-1:0] FILL_V = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_we;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;

    reg_file_sweeper #(
        .ADDR_W(AW), .DATA_W(DW), .N_REGS(NR), .FILL(FILL_V)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Register file with a registered read port and a bench-side bulk preload.
    logic [DW-1:0] rf      [NR];
    logic [DW-1:0] pl_vals [NR];
    logic          pl_en;

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < NR; i++) rf[i] <= pl_vals[i];
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
        rf_rdata <= rf[rf_raddr];
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic [DW-1:0] exp_mem [NR];
    int vectors    = 0;
    int miscompares = 0;

    beat_t         beats[$];
    int            we_cyc[$];
    logic [AW-1:0] we_addr[$];
    logic [DW-1:0] we_data[$];
    int done_cnt, done_cyc, idle_cyc, last_hs, we_seen, ov_seen, wdata_nz;
    int hold_bad, hold_cycles, min_gap, timed_out;

    task automatic preload(input bit incrementing);
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            pl_vals[i] = incrementing ? DW'(32'h1000 + i) : DW'($urandom);
            exp_mem[i] = pl_vals[i];
        end
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Runs one dump; returns early (before the handshake) when beat stop_beat is offered.
    task automatic run_dump(input bit rand_bp, input int hold_beat, input int inj_beat,
                            input int stop_beat);
        int cyc = 0;
        int hold_left = 0;
        bit hold_started = 0;
        bit inj_done = 0;
        bit got_done = 0;
        beats.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; last_hs = -1; we_seen = 0;
        hold_bad = 0; hold_cycles = 0; min_gap = 1000; timed_out = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            mode  = 1'($urandom_range(0, 1));
            if (cyc > 3000) begin timed_out = 1; break; end
            if (stop_beat >= 0 && out_valid && out_addr == AW'(stop_beat)) break;
            if (rf_we) we_seen++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                got_done = 1;
                if (inj_beat >= 0) begin start = 1'b1; mode = 1'($urandom_range(0, 1)); end
            end
            if (got_done && !busy) begin idle_cyc = cyc; break; end
            out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_beat >= 0 && !hold_started && out_valid && out_addr == AW'(hold_beat)) begin
                hold_started = 1;
                hold_left = 5;
            end
            if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
                hold_cycles++;
                if (!(out_valid === 1'b1 && out_addr === AW'(hold_beat)
                      && out_data === exp_mem[hold_beat])) hold_bad++;
            end
            if (inj_beat >= 0 && !inj_done && out_valid && out_addr == AW'(inj_beat)) begin
                start = 1'b1;
                mode = 1'($urandom_range(0, 1));
                inj_done = 1;
            end
            if (out_valid && out_ready) begin
                if (last_hs >= 0 && cyc - last_hs < min_gap) min_gap = cyc - last_hs;
                last_hs = cyc;
                beats.push_back('{a: out_addr, d: out_data});
            end
        end
        out_ready = 1'b1;
    endtask

    // Runs one clear; returns early while write number stop_writes is being presented.
    task automatic run_clear(input int stop_writes);
        int cyc = 0;
        bit got_done = 0;
        we_cyc.delete(); we_addr.delete(); we_data.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; ov_seen = 0; wdata_nz = 0; timed_out = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            mode  = 1'($urandom_range(0, 1));
            if (cyc > 3000) begin timed_out = 1; break; end
            if (stop_writes >= 0 && rf_we && we_cyc.size() == stop_writes) break;
            if (rf_we) begin
                we_cyc.push_back(cyc);
                we_addr.push_back(rf_waddr);
                we_data.push_back(rf_wdata);
            end else if (rf_wdata !== '0) begin
                wdata_nz++;
            end
            if (out_valid) ov_seen++;
            if (done) begin done_cnt++; done_cyc = cyc; got_done = 1; end
            if (got_done && !busy) begin idle_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1; pl_en = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, rf_we, rf_raddr, rf_waddr, rf_wdata, out_valid, out_addr, out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b done=%b we=%b raddr=%0d waddr=%0d wdata=%h valid=%b addr=%0d data=%h, required all zero",
                     busy, done, rf_we, rf_raddr, rf_waddr, rf_wdata, out_valid, out_addr, out_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_dump_basic();
        preload(1);
        run_dump(0, -1, -1, -1);
        vectors++;
        if (timed_out !== 0 || beats.size() != NR) begin
            miscompares++;
            $display("FAIL basic_beat_count: got %0d beats (timeout=%0d), required %0d", beats.size(), timed_out, NR);
        end
        for (int i = 0; i < NR; i++) begin
            vectors++;
            if (i >= beats.size()) begin
                miscompares++;
                $display("FAIL basic_beat%0d: missing, required addr %0d data %h", i, i, exp_mem[i]);
            end else if (beats[i].a !== AW'(i) || beats[i].d !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL basic_beat%0d: got addr %0d data %h, required addr %0d data %h",
                         i, beats[i].a, beats[i].d, i, exp_mem[i]);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_cyc - last_hs != 1 || idle_cyc - done_cyc != 1) begin
            miscompares++;
            $display("FAIL basic_done_timing: done_cnt=%0d done-hs=%0d idle-done=%0d, required 1 1 1",
                     done_cnt, done_cyc - last_hs, idle_cyc - done_cyc);
        end
        vectors++;
        if (we_seen != 0) begin
            miscompares++;
            $display("FAIL basic_no_write: rf_we seen %0d cycles, required 0", we_seen);
        end
        vectors++;
        if (min_gap != 3) begin
            miscompares++;
            $display("FAIL basic_beat_spacing: min gap %0d cycles, required 3", min_gap);
        end
    endtask

    task automatic test_backpressure();
        preload(0);
        run_dump(0, 3, -1, -1);
        vectors++;
        if (hold_cycles != 5 || hold_bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: held %0d cycles with %0d unstable, required 5 and 0", hold_cycles, hold_bad);
        end
        vectors++;
        if (timed_out !== 0 || beats.size() != NR) begin
            miscompares++;
            $display("FAIL bp_beat_count: got %0d beats, required %0d", beats.size(), NR);
        end
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].a !== AW'(i) || beats[i].d !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL bp_beat%0d: got addr %0d data %h, required addr %0d data %h",
                         i, beats[i].a, beats[i].d, i, exp_mem[i]);
            end
        end
    endtask

    task automatic test_random_bp();
        preload(0);
        run_dump(1, -1, -1, -1);
        vectors++;
        if (timed_out !== 0 || beats.size() != NR || done_cnt != 1 || min_gap < 3) begin
            miscompares++;
            $display("FAIL rbp_summary: beats=%0d done_cnt=%0d min_gap=%0d, required %0d 1 >=3",
                     beats.size(), done_cnt, min_gap, NR);
        end
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].a !== AW'(i) || beats[i].d !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL rbp_beat%0d: got addr %0d data %h, required addr %0d data %h",
                         i, beats[i].a, beats[i].d, i, exp_mem[i]);
            end
        end
    endtask

    task automatic test_clear_then_dump();
        preload(0);
        run_clear(-1);
        vectors++;
        if (timed_out !== 0 || we_cyc.size() != NR || we_cyc[NR-1] - we_cyc[0] != NR - 1) begin
            miscompares++;
            $display("FAIL clear_write_run: %0d writes (timeout=%0d), required %0d consecutive", we_cyc.size(), timed_out, NR);
        end
        for (int i = 0; i < NR && i < we_cyc.size(); i++) begin
            vectors++;
            if (we_addr[i] !== AW'(i) || we_data[i] !== FILL_V) begin
                miscompares++;
                $display("FAIL clear_write%0d: got addr %0d data %h, required addr %0d data %h",
                         i, we_addr[i], we_data[i], i, FILL_V);
            end
        end
        vectors++;
        if (done_cnt != 1 || we_cyc.size() == 0 || done_cyc != we_cyc[we_cyc.size()-1] + 1
            || idle_cyc != done_cyc + 1 || ov_seen != 0 || wdata_nz != 0) begin
            miscompares++;
            $display("FAIL clear_done: done_cnt=%0d done_cyc=%0d idle_cyc=%0d valid=%0d wdata_nz=%0d, required 1 after last write",
                     done_cnt, done_cyc, idle_cyc, ov_seen, wdata_nz);
        end
        for (int i = 0; i < NR; i++) exp_mem[i] = FILL_V;
        run_dump(1, -1, -1, -1);
        vectors++;
        if (timed_out !== 0 || beats.size() != NR) begin
            miscompares++;
            $display("FAIL clear_dump_count: got %0d beats, required %0d", beats.size(), NR);
        end
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].a !== AW'(i) || beats[i].d !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL clear_dump_beat%0d: got addr %0d data %h, required addr %0d data %h",
                         i, beats[i].a, beats[i].d, i, exp_mem[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        preload(0);
        run_dump(0, -1, 5, -1);
        vectors++;
        if (timed_out !== 0 || beats.size() != NR || done_cnt != 1 || we_seen != 0) begin
            miscompares++;
            $display("FAIL busy_start: beats=%0d done_cnt=%0d we=%0d, required %0d 1 0",
                     beats.size(), done_cnt, we_seen, NR);
        end
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].a !== AW'(i) || beats[i].d !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL busy_beat%0d: got addr %0d data %h, required addr %0d data %h",
                         i, beats[i].a, beats[i].d, i, exp_mem[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_no_queue: busy=%b %0d cycles after sweep, required 0", busy, k + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        preload(0);
        run_dump(0, -1, -1, 10);
        vectors++;
        if (timed_out !== 0 || beats.size() != 10) begin
            miscompares++;
            $display("FAIL rst_dump_progress: %0d beats before reset, required 10", beats.size());
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, rf_we, rf_raddr, rf_waddr, rf_wdata, out_valid, out_addr, out_data} !== '0) begin
            miscompares++;
            $display("FAIL rst_dump_values: busy=%b valid=%b addr=%0d data=%h raddr=%0d, required all zero",
                     busy, out_valid, out_addr, out_data, rf_raddr);
        end
        @(negedge clk);
        rst = 1'b0;
        run_clear(12);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, rf_we, rf_raddr, rf_waddr, rf_wdata, out_valid, out_addr, out_data} !== '0) begin
            miscompares++;
            $display("FAIL rst_clear_values: busy=%b we=%b waddr=%0d wdata=%h, required all zero",
                     busy, rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (timed_out !== 0 || we_cyc.size() != 12) begin
            miscompares++;
            $display("FAIL rst_clear_progress: %0d writes before reset, required 12", we_cyc.size());
        end
        for (int i = 0; i < 12; i++) exp_mem[i] = FILL_V;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            vectors++;
            if (rf[i] !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL rst_clear_reg%0d: holds %h, required %h", i, rf[i], exp_mem[i]);
            end
        end
        run_dump(1, -1, -1, -1);
        vectors++;
        if (timed_out !== 0 || beats.size() != NR) begin
            miscompares++;
            $display("FAIL rst_redump_count: got %0d beats, required %0d", beats.size(), NR);
        end
        for (int i = 0; i < NR && i < beats.size(); i++) begin
            vectors++;
            if (beats[i].a !== AW'(i) || beats[i].d !== exp_mem[i]) begin
                miscompares++;
                $display("FAIL rst_redump_beat%0d: got addr %0d data %h, required addr %0d data %h",
                         i, beats[i].a, beats[i].d, i, exp_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dump_basic();
        test_backpressure();
        test_random_bp();
        test_clear_then_dump();
        test_start_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
